load_store_unit: RTL
====================

# load_store_unit

Memory-access stage directly downstream of the ALU: takes the ALU result as the effective address and the second register-file read value as store data, performs byte/halfword/word loads and stores against a word-wide data RAM with a valid/ready handshake, and returns sign- or zero-extended load data for register write-back. Misaligned and reserved-size accesses are trapped locally and never reach memory. Sits between the ALU and the register-file write port.

## Interface
- No parameters; address and data are fixed at 32 bits.

- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  execute stage presents a memory operation
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_address  in  32  effective byte address (ALU result)
- req_wdata  in  32  store data, right-aligned (register value 2)
- resp_valid  out  1  one-cycle pulse: operation complete
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  valid with resp_valid: misaligned or reserved size
- mem_valid  out  1  request to data RAM
- mem_ready  in  1  RAM accepts request
- mem_write  out  1  RAM write strobe qualifier
- mem_address  out  32  word-aligned address (bits 1:0 = 0)
- mem_byte_enable  out  4  per-byte write enables, bit i = byte lane i
- mem_wdata  out  32  store data replicated/shifted into lanes
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

## Operation
- Little-endian: byte lane i = address offset i = bits [8i+7:8i].
- States: IDLE, ISSUE, WAIT_READ, RESPOND.
- IDLE: req_ready = 1. On req_valid: latch write, size, unsigned, address, wdata. Alignment check: halfword needs address[0] = 0, word needs address[1:0] = 0, size 3 always errors. Error -> RESPOND with error flag; else -> ISSUE.
- ISSUE: mem_valid = 1, mem_address = {address[31:2], 2'b00}, mem_write = latched write. Held stable until mem_ready. On mem_valid && mem_ready: store -> RESPOND; load -> WAIT_READ.
- Store byte enables: byte 4'b0001 << address[1:0]; halfword 4'b0011 << address[1:0]; word 4'b1111. mem_wdata: byte replicated ×4, halfword replicated ×2, word as is. Loads: mem_byte_enable = 0.
- WAIT_READ: on mem_rvalid, select lane(s) by latched address[1:0], extend per size/unsigned into a result register -> RESPOND.
- RESPOND: resp_valid = 1 for exactly one cycle with resp_rdata/resp_error from registers -> IDLE.
- No back-pressure on response; consumer must take it.
- Error: no mem_valid issued, resp_rdata = 0, resp_error = 1.

## Timing
- Reset (reset_n low at a rising edge): next cycle state IDLE, req_ready = 1, resp_valid = 0, resp_error = 0, resp_rdata = 0, mem_valid = 0, mem_write = 0, mem_byte_enable = 0, mem_address = 0, mem_wdata = 0.
- Reset mid-operation aborts: mem_valid drops the cycle after reset; a late mem_rvalid arriving in IDLE is ignored.
- Request accepted at edge T (req_valid && req_ready).
- Error: resp_valid in cycle T+1.
- Store, mem_ready high immediately: mem_valid in T+1, resp_valid in T+2.
- Load, mem_ready immediate, mem_rvalid in the cycle after acceptance: mem_valid T+1, mem_rvalid T+2, resp_valid T+3 (minimum).
- mem_rvalid is sampled only in WAIT_READ; RAM must return data at least one cycle after the accepting edge.
- Each mem_ready stall or mem_rvalid delay cycle adds one cycle of latency.
- req_ready is low from T+1 until the cycle after RESPOND; back-to-back throughput is one op per (latency + 1) cycles.
- req inputs need be stable only at the accepting edge.

## Test plan
- Word store address 0x100, wdata 0xDEADBEEF, mem_ready immediate -> mem_address 0x100, byte_enable 4'b1111, mem_wdata 0xDEADBEEF, resp_valid at T+2, error 0.
- Byte store address 0x103, wdata 0x000000A5 -> byte_enable 4'b1000, mem_wdata 0xA5A5A5A5, mem_address 0x100.
- Loads from word 0x80FF7F01: lb at offset 0 -> 0x00000001; lb at offset 3 -> 0xFFFFFF80; lbu at offset 3 -> 0x00000080; lh at offset 2 -> 0xFFFF80FF; lhu at offset 2 -> 0x000080FF.
- Halfword load address 0x201 -> no mem_valid, resp_valid at T+1, error 1, rdata 0; size 3 at 0x200 -> same.
- Load with mem_ready held low 3 cycles and mem_rvalid 2 cycles later -> mem_valid/address stable throughout, req_ready low, resp_valid exactly once at T+7.
- reset_n low during WAIT_READ, then mem_rvalid asserted -> no resp_valid, req_ready 1, all outputs at reset values.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-access stage between the ALU and the register-file write port.
//   Takes the effective address and store data, and runs byte/halfword/word
//   loads and stores against a word-wide data RAM. Returns sign- or
//   zero-extended load data. Misaligned and reserved-size accesses are
//   trapped here and never reach the RAM.
//
// Ports
//   i_clock, i_reset_n      rising-edge clock, synchronous active-low reset
//   i_req_*, o_req_ready    request from execute (valid/ready handshake)
//   o_resp_*                one-cycle completion pulse with data / error
//   o_mem_*, i_mem_*        data RAM request, write lanes and read return
//
// States
//   S_IDLE      | ready for a request, latches it on accept
//   S_ISSUE     | mem_valid held until the RAM takes it
//   S_WAIT_READ | load issued, waiting for mem_rvalid
//   S_RESPOND   | one-cycle response pulse
module load_store_unit (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_address,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_error,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic        o_mem_write,
  output logic [31:0] o_mem_address,
  output logic [3:0]  o_mem_byte_enable,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_READ = 2'd2,
    S_RESPOND   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_address;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_error;

  logic        w_misaligned;
  logic [31:0] w_lane_data;
  logic [31:0] w_load_value;

  // Size 3 is reserved and always traps.
  always_comb begin
    case (i_req_size)
      2'd0:    w_misaligned = 1'b0;
      2'd1:    w_misaligned = i_req_address[0];
      2'd2:    w_misaligned = |i_req_address[1:0];
      default: w_misaligned = 1'b1;
    endcase
  end

  // Move the addressed lane down to bit 0, then extend.
  assign w_lane_data = i_mem_rdata >> {r_address[1:0], 3'b000};

  always_comb begin
    case (r_size)
      2'd0:    w_load_value = {{24{~r_unsigned & w_lane_data[7]}}, w_lane_data[7:0]};
      2'd1:    w_load_value = {{16{~r_unsigned & w_lane_data[15]}}, w_lane_data[15:0]};
      default: w_load_value = w_lane_data;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state      = r_state;
    o_req_ready       = 1'b0;
    o_mem_valid       = 1'b0;
    o_mem_write       = 1'b0;
    o_mem_address     = 32'd0;
    o_mem_byte_enable = 4'd0;
    o_mem_wdata       = 32'd0;
    o_resp_valid      = 1'b0;
    o_resp_rdata      = 32'd0;
    o_resp_error      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          w_next_state = w_misaligned ? S_RESPOND : S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_mem_valid   = 1'b1;
        o_mem_write   = r_write;
        o_mem_address = {r_address[31:2], 2'b00};
        if (r_write) begin
          case (r_size)
            2'd0: begin
              o_mem_byte_enable = 4'b0001 << r_address[1:0];
              o_mem_wdata       = {4{r_wdata[7:0]}};
            end
            2'd1: begin
              o_mem_byte_enable = 4'b0011 << r_address[1:0];
              o_mem_wdata       = {2{r_wdata[15:0]}};
            end
            default: begin
              o_mem_byte_enable = 4'b1111;
              o_mem_wdata       = r_wdata;
            end
          endcase
        end
        if (i_mem_ready) begin
          w_next_state = r_write ? S_RESPOND : S_WAIT_READ;
        end
      end
      S_WAIT_READ: begin
        if (i_mem_rvalid) begin
          w_next_state = S_RESPOND;
        end
      end
      S_RESPOND: begin
        o_resp_valid = 1'b1;
        o_resp_rdata = r_rdata;
        o_resp_error = r_error;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_write    <= 1'b0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_address  <= 32'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_write    <= i_req_write;
            r_size     <= i_req_size;
            r_unsigned <= i_req_unsigned;
            r_address  <= i_req_address;
            r_wdata    <= i_req_wdata;
            // Stores and trapped accesses respond with zero data.
            r_rdata    <= 32'd0;
            r_error    <= w_misaligned;
          end
        end
        S_WAIT_READ: begin
          if (i_mem_rvalid) begin
            r_rdata <= w_load_value;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
